// File: rtl/load_store_unit.sv
// Memory stage of the 5-stage MIPS pipeline: runs loads/stores over a req/ack data-memory port,
// steers big-endian sub-word lanes, extends load data and forwards ALU results to writeback.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_load,
   input  logic         in_store,
   input  logic [0:1]   in_size,
   input  logic         in_unsigned,
   input  logic [0:31]  in_addr,
   input  logic [0:31]  in_wdata,
   input  logic [0:31]  in_alu,
   input  logic [0:4]   in_rd,
   input  logic         in_we,
   output logic         mem_req,
   output logic         mem_wren,
   output logic [0:31]  mem_addr,
   output logic [0:3]   mem_be,
   output logic [0:31]  mem_wdata,
   input  logic [0:31]  mem_rdata,
   input  logic         mem_ack,
   output logic         wb_valid,
   output logic         wb_we,
   output logic [0:4]   wb_rd,
   output logic [0:31]  wb_data,
   output logic         exc,
   output logic [0:1]   exc_code,
   output logic [0:31]  exc_addr
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [0:1] SZ_BYTE = 2'b00;
   localparam logic [0:1] SZ_HALF = 2'b01;
   localparam logic [0:1] SZ_WORD = 2'b10;
   localparam logic [0:1] SZ_ILL  = 2'b11;

   localparam logic [0:1] EXC_MISALIGN = 2'b01;
   localparam logic [0:1] EXC_TIMEOUT  = 2'b10;
   localparam logic [0:1] EXC_ILLEGAL  = 2'b11;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         ld_q, ld_d;
   logic [0:1]   size_q, size_d;
   logic         uns_q, uns_d;
   logic         we_q, we_d;
   logic [0:4]   rd_q, rd_d;
   logic [0:31]  addr_q, addr_d;

   logic         mem_req_q, mem_req_d;
   logic         mem_wren_q, mem_wren_d;
   logic [0:31]  mem_addr_q, mem_addr_d;
   logic [0:3]   mem_be_q, mem_be_d;
   logic [0:31]  mem_wdata_q, mem_wdata_d;
   logic         wb_valid_q, wb_valid_d;
   logic         wb_we_q, wb_we_d;
   logic [0:4]   wb_rd_q, wb_rd_d;
   logic [0:31]  wb_data_q, wb_data_d;
   logic         exc_q, exc_d;
   logic [0:1]   exc_code_q, exc_code_d;
   logic [0:31]  exc_addr_q, exc_addr_d;

   logic         is_mem, is_illegal, is_misaligned;
   logic [0:3]   req_be;
   logic [0:31]  req_wdata;
   logic [0:31]  rd_shift, load_data;

   always_comb begin
      is_mem        = in_load | in_store;
      is_illegal    = (in_load & in_store) | (is_mem & (in_size == SZ_ILL));
      is_misaligned = is_mem & (((in_size == SZ_HALF) & in_addr[31]) |
                                ((in_size == SZ_WORD) & (in_addr[30:31] != 2'b00)));
   end

   // Lane 0 is the most significant byte, so shifting right walks toward higher byte offsets.
   always_comb begin
      case (in_size)
         SZ_BYTE: begin
            req_be    = 4'b1000 >> in_addr[30:31];
            req_wdata = {in_wdata[24:31], 24'h0} >> {in_addr[30:31], 3'b000};
         end
         SZ_HALF: begin
            req_be    = 4'b1100 >> in_addr[30:31];
            req_wdata = {in_wdata[16:31], 16'h0} >> {in_addr[30:31], 3'b000};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = in_wdata;
         end
      endcase
   end

   always_comb begin
      rd_shift = mem_rdata << {addr_q[30:31], 3'b000};
      case (size_q)
         SZ_BYTE: load_data = {{24{rd_shift[0] & ~uns_q}}, rd_shift[0:7]};
         SZ_HALF: load_data = {{16{rd_shift[0] & ~uns_q}}, rd_shift[0:15]};
         default: load_data = rd_shift;
      endcase
   end

   always_comb begin
      // NOTE: every _d defaults to its _q (pulses to 0) before any branch, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_d        = ld_q;
      size_d      = size_q;
      uns_d       = uns_q;
      we_d        = we_q;
      rd_d        = rd_q;
      addr_d      = addr_q;
      mem_req_d   = mem_req_q;
      mem_wren_d  = mem_wren_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      wb_valid_d  = 1'b0;
      wb_we_d     = wb_we_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      exc_d       = 1'b0;
      exc_code_d  = exc_code_q;
      exc_addr_d  = exc_addr_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_illegal || is_misaligned) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_rd_d    = in_rd;
                  exc_d      = 1'b1;
                  exc_code_d = is_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                  exc_addr_d = in_addr;
               end else if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = in_we;
                  wb_rd_d    = in_rd;
                  wb_data_d  = in_alu;
               end else begin
                  state_d     = S_WAIT;
                  cnt_d       = 8'd0;
                  ld_d        = in_load;
                  size_d      = in_size;
                  uns_d       = in_unsigned;
                  we_d        = in_we;
                  rd_d        = in_rd;
                  addr_d      = in_addr;
                  mem_req_d   = 1'b1;
                  mem_wren_d  = in_store;
                  mem_addr_d  = {in_addr[0:29], 2'b00};
                  mem_be_d    = req_be;
                  mem_wdata_d = in_store ? req_wdata : 32'h0;
               end
            end
         end

         S_WAIT: begin
            // An ack in the final counted cycle takes priority over the timeout.
            if (mem_ack) begin
               state_d    = S_IDLE;
               mem_req_d  = 1'b0;
               mem_wren_d = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_we_d    = ld_q & we_q;
               if (ld_q) begin
                  wb_data_d = load_data;
               end
            end else if (cnt_q == LAST_WAIT) begin
               state_d    = S_IDLE;
               mem_req_d  = 1'b0;
               mem_wren_d = 1'b0;
               wb_valid_d = 1'b1;
               wb_we_d    = 1'b0;
               wb_rd_d    = rd_q;
               exc_d      = 1'b1;
               exc_code_d = EXC_TIMEOUT;
               exc_addr_d = addr_q;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         ld_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         we_q        <= 1'b0;
         rd_q        <= 5'd0;
         addr_q      <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_wren_q  <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'h0;
         exc_q       <= 1'b0;
         exc_code_q  <= 2'b00;
         exc_addr_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_q        <= ld_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         we_q        <= we_d;
         rd_q        <= rd_d;
         addr_q      <= addr_d;
         mem_req_q   <= mem_req_d;
         mem_wren_q  <= mem_wren_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_we_q     <= wb_we_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         exc_q       <= exc_d;
         exc_code_q  <= exc_code_d;
         exc_addr_q  <= exc_addr_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_wren  = mem_wren_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_we     = wb_we_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign exc       = exc_q;
   assign exc_code  = exc_code_q;
   assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner
// sequences and randomized traffic against a byte-lane memory model.
module tb_load_store_unit;

   localparam int TO = 4;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_load, in_store;
   logic [0:1]   in_size;
   logic         in_unsigned;
   logic [0:31]  in_addr, in_wdata, in_alu;
   logic [0:4]   in_rd;
   logic         in_we;
   logic         mem_req, mem_wren;
   logic [0:31]  mem_addr;
   logic [0:3]   mem_be;
   logic [0:31]  mem_wdata, mem_rdata;
   logic         mem_ack;
   logic         wb_valid, wb_we;
   logic [0:4]   wb_rd;
   logic [0:31]  wb_data;
   logic         exc;
   logic [0:1]   exc_code;
   logic [0:31]  exc_addr;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu), .in_rd(in_rd), .in_we(in_we),
      .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc(exc), .exc_code(exc_code), .exc_addr(exc_addr)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        ld, st;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr, wdata, alu;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] rdata;
      logic        req, wren;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic        wbwe, chk;
      logic [31:0] wbdata;
      logic        ex;
      logic [1:0]  code;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] al,
                           input logic [4:0] rd, input logic we);
      in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
      in_addr = a; in_wdata = wd; in_alu = al; in_rd = rd; in_we = we;
      in_valid = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      drive_op(v.ld, v.st, v.sz, v.uns, v.addr, v.wdata, v.alu, v.rd, v.we);
      step();
      in_valid = 1'b0;
      if (v.req) begin
         check($sformatf("vec%0d_req", idx), mem_req, 1);
         check($sformatf("vec%0d_ready", idx), in_ready, 0);
         check($sformatf("vec%0d_maddr", idx), mem_addr, v.maddr);
         check($sformatf("vec%0d_be", idx), mem_be, v.be);
         check($sformatf("vec%0d_wren", idx), mem_wren, v.wren);
         if (v.wren) check($sformatf("vec%0d_mwdata", idx), mem_wdata, v.mwdata);
         mem_rdata = v.rdata;
         mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
      end else begin
         check($sformatf("vec%0d_noreq", idx), mem_req, 0);
      end
      check($sformatf("vec%0d_wbvalid", idx), wb_valid, 1);
      check($sformatf("vec%0d_wbwe", idx), wb_we, v.wbwe);
      check($sformatf("vec%0d_exc", idx), exc, v.ex);
      if (v.ex) begin
         check($sformatf("vec%0d_code", idx), exc_code, v.code);
         check($sformatf("vec%0d_excaddr", idx), exc_addr, v.addr);
      end
      if (v.chk) begin
         check($sformatf("vec%0d_wbdata", idx), wb_data, v.wbdata);
         check($sformatf("vec%0d_wbrd", idx), wb_rd, v.rd);
      end
   endtask

   // Randomized-traffic state: the bench memory answers the DUT, the model memory predicts it.
   logic [31:0] mem_arr[16];
   logic [31:0] model_mem[16];
   logic        r_ld, r_st, r_uns, r_we, r_illegal, r_mis;
   logic [1:0]  r_sz;
   logic [31:0] r_a, r_wd, r_al, r_exp_wd, r_exp_ld, r_mask, r_ma, r_wdv;
   logic [4:0]  r_rd;
   logic [3:0]  r_be, r_be4;
   int          r_kind, r_off, r_bytes, r_lat, r_wi, r_shift, r_waits;

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      in_valid = 1'b0;

      vecs[0]  = '{1'b1,1'b0,2'b00,1'b0,32'h10000001,32'h0,32'h0,5'd3,1'b1,32'h12803456, 1'b1,1'b0,32'h10000000,4'b0100,32'h0,1'b1,1'b1,32'hFFFFFF80,1'b0,2'b00};
      vecs[1]  = '{1'b1,1'b0,2'b00,1'b1,32'h10000001,32'h0,32'h0,5'd4,1'b1,32'h12803456, 1'b1,1'b0,32'h10000000,4'b0100,32'h0,1'b1,1'b1,32'h00000080,1'b0,2'b00};
      vecs[2]  = '{1'b0,1'b1,2'b01,1'b0,32'h10000006,32'h1234BEEF,32'h0,5'd5,1'b1,32'h0, 1'b1,1'b1,32'h10000004,4'b0011,32'h0000BEEF,1'b0,1'b0,32'h0,1'b0,2'b00};
      vecs[3]  = '{1'b1,1'b0,2'b10,1'b0,32'h10000002,32'h0,32'h0,5'd6,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b0,32'h0,1'b1,2'b01};
      vecs[4]  = '{1'b0,1'b0,2'b10,1'b0,32'h0,32'h0,32'hDEADBEEF,5'd7,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b1,1'b1,32'hDEADBEEF,1'b0,2'b00};
      vecs[5]  = '{1'b1,1'b1,2'b10,1'b0,32'h00000100,32'h0,32'h0,5'd8,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b0,32'h0,1'b1,2'b11};
      vecs[6]  = '{1'b1,1'b0,2'b11,1'b0,32'h00000200,32'h0,32'h0,5'd8,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b0,32'h0,1'b1,2'b11};
      vecs[7]  = '{1'b1,1'b0,2'b01,1'b0,32'h20000002,32'h0,32'h0,5'd9,1'b1,32'h1234F00D, 1'b1,1'b0,32'h20000000,4'b0011,32'h0,1'b1,1'b1,32'hFFFFF00D,1'b0,2'b00};
      vecs[8]  = '{1'b1,1'b0,2'b01,1'b1,32'h20000000,32'h0,32'h0,5'd10,1'b1,32'h8001ABCD, 1'b1,1'b0,32'h20000000,4'b1100,32'h0,1'b1,1'b1,32'h00008001,1'b0,2'b00};
      vecs[9]  = '{1'b0,1'b1,2'b00,1'b0,32'h30000003,32'hAABBCC5A,32'h0,5'd11,1'b1,32'h0, 1'b1,1'b1,32'h30000000,4'b0001,32'h0000005A,1'b0,1'b0,32'h0,1'b0,2'b00};
      vecs[10] = '{1'b0,1'b1,2'b10,1'b0,32'h40000008,32'hCAFEF00D,32'h0,5'd12,1'b1,32'h0, 1'b1,1'b1,32'h40000008,4'b1111,32'hCAFEF00D,1'b0,1'b0,32'h0,1'b0,2'b00};
      vecs[11] = '{1'b1,1'b0,2'b01,1'b0,32'h20000001,32'h0,32'h0,5'd13,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b0,32'h0,1'b1,2'b01};
      vecs[12] = '{1'b1,1'b0,2'b10,1'b0,32'h50000004,32'h0,32'h0,5'd31,1'b1,32'h89ABCDEF, 1'b1,1'b0,32'h50000004,4'b1111,32'h0,1'b1,1'b1,32'h89ABCDEF,1'b0,2'b00};
      vecs[13] = '{1'b1,1'b0,2'b00,1'b0,32'h60000003,32'h0,32'h0,5'd14,1'b1,32'h0000007F, 1'b1,1'b0,32'h60000000,4'b0001,32'h0,1'b1,1'b1,32'h0000007F,1'b0,2'b00};
      vecs[14] = '{1'b0,1'b1,2'b01,1'b0,32'h00000010,32'hFFFF1234,32'h0,5'd15,1'b1,32'h0, 1'b1,1'b1,32'h00000010,4'b1100,32'h12340000,1'b0,1'b0,32'h0,1'b0,2'b00};
      vecs[15] = '{1'b0,1'b1,2'b00,1'b0,32'h00000020,32'h000000C3,32'h0,5'd16,1'b1,32'h0, 1'b1,1'b1,32'h00000020,4'b1000,32'hC3000000,1'b0,1'b0,32'h0,1'b0,2'b00};
      vecs[16] = '{1'b0,1'b0,2'b00,1'b0,32'h0,32'h0,32'h12345678,5'd0,1'b0,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b1,32'h12345678,1'b0,2'b00};
      vecs[17] = '{1'b0,1'b1,2'b10,1'b0,32'h00000007,32'h0,32'h0,5'd17,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b0,1'b0,32'h0,1'b1,2'b01};

      // Reset values while reset is held.
      repeat (2) @(posedge clock);
      #1;
      check("rst_ready", in_ready, 1);
      check("rst_req", mem_req, 0);
      check("rst_wren", mem_wren, 0);
      check("rst_be", mem_be, 0);
      check("rst_maddr", mem_addr, 0);
      check("rst_mwdata", mem_wdata, 0);
      check("rst_wbvalid", wb_valid, 0);
      check("rst_wbwe", wb_we, 0);
      check("rst_wbrd", wb_rd, 0);
      check("rst_wbdata", wb_data, 0);
      check("rst_exc", exc, 0);
      check("rst_code", exc_code, 0);
      check("rst_excaddr", exc_addr, 0);
      @(negedge clock) reset_n = 1'b1;
      step();
      check("post_rst_ready", in_ready, 1);

      for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

      // Timeout: ack never arrives, mem_req must stay high exactly TO cycles.
      drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h70000010, 32'h0, 32'h0, 5'd20, 1'b1);
      step();
      in_valid = 1'b0;
      r_waits = 0;
      while (mem_req === 1'b1 && r_waits < 20) begin
         check("to_addr_stable", mem_addr, 32'h70000010);
         r_waits++;
         step();
      end
      check("to_req_cycles", r_waits, TO);
      check("to_wbvalid", wb_valid, 1);
      check("to_exc", exc, 1);
      check("to_code", exc_code, 2'b10);
      check("to_excaddr", exc_addr, 32'h70000010);
      check("to_wbwe", wb_we, 0);
      check("to_ready", in_ready, 1);
      step();
      check("to_exc_pulse", exc, 0);
      check("to_wb_pulse", wb_valid, 0);

      // Ack in the last counted WAIT cycle completes normally.
      drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h70000020, 32'h0, 32'h0, 5'd21, 1'b1);
      step();
      in_valid = 1'b0;
      repeat (TO - 1) step();
      check("lastack_req", mem_req, 1);
      mem_rdata = 32'h0BADF00D;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("lastack_wbvalid", wb_valid, 1);
      check("lastack_exc", exc, 0);
      check("lastack_data", wb_data, 32'h0BADF00D);
      check("lastack_wbwe", wb_we, 1);
      check("lastack_req_drop", mem_req, 0);

      // Ten back-to-back ALU ops, then a store with ack in its third WAIT cycle.
      for (int i = 0; i < 10; i++) begin
         drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'hA0000000 + 32'(i), 5'(i + 1), 1'b1);
         step();
         check("b2b_wbvalid", wb_valid, 1);
         check("b2b_data", wb_data, 32'hA0000000 + 32'(i));
         check("b2b_ready", in_ready, 1);
      end
      drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h00000040, 32'h55AA55AA, 32'h0, 5'd2, 1'b1);
      step();
      in_valid = 1'b0;
      r_waits = 0;
      for (int k = 0; k < 10 && in_ready === 1'b0; k++) begin
         r_waits++;
         if (r_waits == 3) mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
      end
      check("sw_stall_cycles", r_waits, 3);
      check("sw_wbvalid", wb_valid, 1);
      check("sw_wbwe", wb_we, 0);

      // Randomized traffic against the byte-lane model.
      for (int j = 0; j < 16; j++) begin
         mem_arr[j] = $urandom;
         model_mem[j] = mem_arr[j];
      end
      for (int n = 0; n < 300; n++) begin
         r_kind = $urandom_range(0, 9);
         r_ld = (r_kind >= 3 && r_kind <= 5) || r_kind == 9;
         r_st = (r_kind >= 6);
         r_sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_uns = 1'($urandom_range(0, 1));
         r_we = 1'($urandom_range(0, 1));
         r_rd = 5'($urandom_range(0, 31));
         r_wd = $urandom;
         r_al = $urandom;
         r_a = 32'h10000000 | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == 2'b01) r_a[0] = 1'b0;
            if (r_sz == 2'b10) r_a[1:0] = 2'b00;
         end
         r_off = int'(r_a[1:0]);
         r_wi = int'(r_a[5:2]);
         r_bytes = 1 << r_sz;
         r_illegal = (r_ld && r_st) || ((r_ld || r_st) && r_sz == 2'b11);
         r_mis = !r_illegal && (r_ld || r_st) && ((r_sz == 2'b01 && r_off % 2 != 0) || (r_sz == 2'b10 && r_off != 0));

         drive_op(r_ld, r_st, r_sz, r_uns, r_a, r_wd, r_al, r_rd, r_we);
         step();

         if (r_illegal || r_mis || !(r_ld || r_st)) begin
            in_valid = 1'b0;
            check("rnd_wbvalid", wb_valid, 1);
            check("rnd_noreq", mem_req, 0);
            check("rnd_exc", exc, r_illegal || r_mis);
            if (r_illegal || r_mis) begin
               check("rnd_code", exc_code, r_illegal ? 2'b11 : 2'b01);
               check("rnd_excaddr", exc_addr, r_a);
               check("rnd_fault_wbwe", wb_we, 0);
            end else begin
               check("rnd_alu_data", wb_data, r_al);
               check("rnd_alu_rd", wb_rd, r_rd);
               check("rnd_alu_we", wb_we, r_we);
            end
         end else begin
            r_be = 4'b0000;
            for (int k = 0; k < 4; k++)
               if (k >= r_off && k < r_off + r_bytes) r_be[3 - k] = 1'b1;
            r_shift = 8 * (4 - r_off - r_bytes);
            r_mask = 32'((64'd1 << (8 * r_bytes)) - 64'd1);
            r_exp_wd = (r_wd & r_mask) << r_shift;
            r_exp_ld = (model_mem[r_wi] >> r_shift) & r_mask;
            if (!r_uns && r_bytes < 4 && r_exp_ld[8 * r_bytes - 1]) r_exp_ld = r_exp_ld | ~r_mask;
            r_lat = $urandom_range(1, TO + 1);

            check("rnd_wb_quiet", wb_valid, 0);
            check("rnd_stall", in_ready, 0);
            check("rnd_be", mem_be, r_be);
            check("rnd_wren", mem_wren, r_st);
            if (r_st) check("rnd_mwdata", mem_wdata, r_exp_wd);
            for (int w = 1; w <= TO; w++) begin
               check("rnd_req_hold", mem_req, 1);
               check("rnd_addr_hold", mem_addr, {r_a[31:2], 2'b00});
               if (w == r_lat) begin
                  r_ma = mem_addr;
                  r_be4 = mem_be;
                  r_wdv = mem_wdata;
                  mem_rdata = r_st ? $urandom : mem_arr[r_ma[5:2]];
                  if (r_st)
                     for (int k = 0; k < 4; k++)
                        if (r_be4[3 - k]) mem_arr[r_ma[5:2]][31 - 8 * k -: 8] = r_wdv[31 - 8 * k -: 8];
                  mem_ack = 1'b1;
               end
               step();
               mem_ack = 1'b0;
               if (w == r_lat) break;
            end
            in_valid = 1'b0;
            check("rnd_done_wbvalid", wb_valid, 1);
            check("rnd_done_ready", in_ready, 1);
            check("rnd_done_req", mem_req, 0);
            if (r_lat > TO) begin
               check("rnd_to_exc", exc, 1);
               check("rnd_to_code", exc_code, 2'b10);
               check("rnd_to_excaddr", exc_addr, r_a);
               check("rnd_to_wbwe", wb_we, 0);
            end else begin
               check("rnd_ack_exc", exc, 0);
               if (r_ld) begin
                  check("rnd_ld_data", wb_data, r_exp_ld);
                  check("rnd_ld_rd", wb_rd, r_rd);
                  check("rnd_ld_we", wb_we, r_we);
               end else begin
                  check("rnd_st_we", wb_we, 0);
                  for (int k = 0; k < 4; k++)
                     if (r_be[3 - k]) model_mem[r_wi][31 - 8 * k -: 8] = r_exp_wd[31 - 8 * k -: 8];
               end
            end
         end
      end
      for (int j = 0; j < 16; j++) check("rnd_mem_final", mem_arr[j], model_mem[j]);

      // Reset during WAIT: request drops at once, the access is discarded.
      drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10000010, 32'h0, 32'h0, 5'd9, 1'b1);
      step();
      in_valid = 1'b0;
      check("rstw_req_before", mem_req, 1);
      #1 reset_n = 1'b0;
      #1;
      check("rstw_req_async", mem_req, 0);
      check("rstw_ready_async", in_ready, 1);
      @(negedge clock) reset_n = 1'b1;
      step();
      check("rstw_ready", in_ready, 1);
      check("rstw_wbvalid", wb_valid, 0);
      check("rstw_req", mem_req, 0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("idle_ack_wbvalid", wb_valid, 0);
      check("idle_ack_req", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage block between Execute and writeBack in the 5-stage MIPS pipeline. It accepts one operation per handshake from the X/M boundary and runs loads and stores against the data memory using a request/acknowledge protocol. It performs big-endian sub-word lane steering and sign/zero extension, and passes non-memory results straight through. It also stalls upstream while an access is outstanding and reports misalignment, illegal-op and timeout exceptions.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles before an access is abandonded (legal range 1–255).

Ports (bit 0 is the MSB on all buses):
- clock  in  1  rising-edge clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operation present from X/M
- in_ready  out  1  block can accept; upstream stalls when low
- in_load, in_store  in  1 each  operation type
- in_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- in_unsigned  in  1  zero-extend loads (lbu/lhu)
- in_addr  in  32  effective address
- in_wdata  in  32  store data, right-justified
- in_alu  in  32  ALU result for non-memory operations
- in_rd  in  5  destination register
- in_we  in  1  operation writes a register
- mem_req  out  1  access request
- mem_wren  out  1  1 = write
- mem_addr  out  32  word address; bits [30:31] are always 0
- mem_be  out  4  byte enables; be[0] is byte offset 0 (bits 0:7)
- mem_wdata  out  32  lane-placed store data
- mem_rdata  in  32  read word, valid while mem_ack is high
- mem_ack  in  1  access complete
- wb_valid, wb_we  out  1 each  writeback strobe and register write enable
- wb_rd  out  5  writeback destination register
- wb_data  out  32  writeback data
- exc  out  1  exception pulse, coincident with wb_valid
- exc_code  out  2  01 misaligned, 10 timeout, 11 illegal op
- exc_addr  out  32  in_addr of the faulting operation

## Operation
- States:
  - IDLE: in_ready=1.
  - WAIT: in_ready=0, mem_req=1.
- Accept condition: in_valid & in_ready.
- On accept in IDLE:
  - Illegal op (in_load & in_store, or a memory op with in_size=11): wb_valid=1, wb_we=0, exc=1, exc_code=11. No memory request. Stay in IDLE.
  - Misaligned access (half with addr[31]=1; word with addr[30:31]≠00): exc_code=01, otherwise handled as the illegal-op case.
  - Non-memory op: wb_data=in_alu, wb_we=in_we, wb_rd=in_rd. Stay in IDLE.
  - Aligned load or store: register the request fields and enter WAIT.
- Store lane placement:
  - Byte at offset k: data goes to lane k, all other lanes are 0, be is one-hot at k.
  - Half at offset 0: lanes 0–1, be=1100.
  - Half at offset 2: lanes 2–3, be=0011.
  - Word: be=1111.
- Load requests drive be as for a store of the same size. mem_wren=0.
- In WAIT with mem_ack=1, transition to IDLE:
  - Load: select the addressed lane(s) from mem_rdata, right-justify, then sign- or zero-extend per in_unsigned. wb_we=registered in_we.
  - Store: wb_we=0.
  - In both cases wb_valid=1 for one cycle.
- Timeout: the counter clears on entry to WAIT and increments each WAIT cycle.
  - If the TIMEOUT-th WAIT cycle ends without mem_ack: go to IDLE, drop mem_req, wb_valid=1, wb_we=0, exc=1, exc_code=10.
  - mem_ack arriving in that same final cycle wins; no exception is raised.
- mem_ack in IDLE is ignored.
- in_valid while in WAIT is not accepted; upstream holds the operation.

## Timing
- All outputs are registered except in_ready, which is decoded directly from state.
- Reset values: state IDLE; mem_req, mem_wren, wb_valid, wb_we, exc = 0; mem_be=0000; mem_addr, mem_wdata, wb_data, exc_addr = 0; wb_rd=0; exc_code=00; counter=0.
- Non-memory and faulting operations: accepted in cycle N, wb_valid high in N+1. Sustains one operation per cycle.
- Memory operations:
  - Accepted in cycle N; mem_req is high from N+1.
  - If mem_ack arrives in cycle M ≥ N+1, wb_valid is high in M+1 and in_ready returns to 1 in M+1.
  - Minimum 2 cycles per memory operation, i.e. 1 stall cycle.
- mem_req, mem_addr, mem_be, mem_wren and mem_wdata are stable for the entire WAIT period. mem_req falls in the cycle after ack or timeout.
- wb_valid and exc are single-cycle pulses. The wb_* and exc_addr fields hold their values until the next pulse.
- Reset asserted mid-WAIT: mem_req drops immediately (asynchronously), no wb_valid is produced, and the outstanding access is discarded.

## Test plan
- lb at 0x10000001 (in_unsigned=0), mem_rdata=0x12803456, ack in first WAIT cycle -> mem_addr=0x10000000, be=0100, wb_data=0xFFFFFF80, wb_valid 2 cycles after accept. Repeat with in_unsigned=1 (lbu) -> wb_data=0x00000080.
- sh at 0x10000006 with in_wdata=0x1234BEEF -> mem_wren=1, mem_addr=0x10000004, be=0011, mem_wdata=0x0000BEEF, wb_we=0 after ack.
- lw at 0x10000002 -> no mem_req; next cycle exc=1, exc_code=01, exc_addr=0x10000002, wb_we=0.
- TIMEOUT=4, lw with mem_ack held low -> mem_req high for exactly 4 cycles, then exc_code=10. A second run with ack in WAIT cycle 4 -> normal completion, no exc.
- reset_n pulsed low during WAIT -> mem_req=0 immediately, in_ready=1 after release, no wb_valid.
- Ten back-to-back ALU ops, then sw with 3-cycle ack latency -> wb_valid every cycle for the ALU ops; in_ready low for exactly 3 cycles during the sw.
